// File: rtl/lsu_mem_master.sv
// Load/store unit front end for a single-port synchronous word memory.
// Sub-word stores use read-modify-write; loads are extracted and extended.
// Misaligned addresses and the illegal size code complete at once with an
// error and never touch memory.
module lsu_mem_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [1:0]            cmd_size,
  input  logic                  cmd_unsigned,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdCap, StRmwRd, StRmwMerge, StWrReq, StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;

  logic                  accept;
  logic                  illegal;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merge_word;

  assign accept  = cmd_valid && (state_q == StIdle);
  assign illegal = (cmd_size == 2'd3) ||
                   ((cmd_size == 2'd1) && cmd_addr[0]) ||
                   ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00));

  assign mem_addr  = {2'b00, addr_q[ADDR_WIDTH-1:2]};
  // Word stores bypass the merge register entirely.
  assign mem_wdata = (size_q == 2'd2) ? wdata_q : merge_q;

  // Next-state and per-state control outputs.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    mem_request = 1'b0;
    mem_we      = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (illegal)                 state_d = StResp;
          else if (!cmd_we)            state_d = StRdReq;
          else if (cmd_size == 2'd2)   state_d = StWrReq;
          else                         state_d = StRmwRd;
        end
      end
      StRdReq: begin
        mem_request = 1'b1;
        state_d     = StRdCap;
      end
      StRdCap: state_d = StResp;
      StRmwRd: begin
        mem_request = 1'b1;
        state_d     = StRmwMerge;
      end
      StRmwMerge: state_d = StWrReq;
      StWrReq: begin
        mem_request = 1'b1;
        mem_we      = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Select the addressed byte/half of the read word and extend it.
  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_q[1:0])
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'd0:    load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Overlay the low store bits onto the addressed lane of the read word.
  always_comb begin
    merge_word = mem_rdata;
    if (size_q == 2'd0) begin
      unique case (addr_q[1:0])
        2'd0: merge_word[7:0]   = wdata_q[7:0];
        2'd1: merge_word[15:8]  = wdata_q[7:0];
        2'd2: merge_word[23:16] = wdata_q[7:0];
        2'd3: merge_word[31:24] = wdata_q[7:0];
        default: merge_word = mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q[15:0];
    end else begin
      merge_word[15:0] = wdata_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Command latch, response registers and merge buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= cmd_we;
        size_q    <= cmd_size;
        uns_q     <= cmd_unsigned;
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        rsp_rdata <= '0;
        // Error flag is known at accept; it stays stable through RESP.
        rsp_err   <= illegal;
      end
      if (state_q == StRdCap && !we_q) rsp_rdata <= load_ext;
      if (state_q == StRmwMerge)       merge_q   <= merge_word;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural single-port memory.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_unsigned;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_request, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:15];

  int total = 0;
  int bad   = 0;

  // Per-cycle log, index k = k-th cycle after the accept edge.
  logic        lg_req [1:10];
  logic        lg_we  [1:10];
  logic        lg_rv  [1:10];
  logic        lg_err [1:10];
  logic        lg_rdy [1:10];
  logic [31:0] lg_addr[1:10];
  logic [31:0] lg_wd  [1:10];
  logic [31:0] lg_rd  [1:10];

  lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_size     (cmd_size),
    .cmd_unsigned (cmd_unsigned),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_request  (mem_request),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_request && mem_we)  mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_request && !mem_we) mem_rdata <= mem[mem_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_size = size; cmd_unsigned = uns;
    cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic observe(input int n);
    for (int k = 1; k <= n; k++) begin
      lg_req[k] = mem_request; lg_we[k] = mem_we; lg_rv[k] = rsp_valid;
      lg_err[k] = rsp_err; lg_rdy[k] = cmd_ready; lg_addr[k] = mem_addr;
      lg_wd[k] = mem_wdata; lg_rd[k] = rsp_rdata;
      @(posedge clk); #1;
    end
  endtask

  function automatic int lat(input int n);
    for (int k = 1; k <= n; k++) if (lg_rv[k]) return k;
    return 0;
  endfunction

  function automatic int nreq(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (lg_req[k]) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = 2'd0; cmd_unsigned = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_req", {31'b0, mem_request}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);

    // Load word at 0x10.
    mem[4] = 32'hDEADBEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    observe(6);
    check("lw_req1", {31'b0, lg_req[1]}, 32'd1);
    check("lw_we1", {31'b0, lg_we[1]}, 32'd0);
    check("lw_addr1", lg_addr[1], 32'd4);
    check("lw_lat", 32'(lat(6)), 32'd3);
    check("lw_data", lg_rd[3], 32'hDEADBEEF);
    check("lw_hold", rsp_rdata, 32'hDEADBEEF);

    // Sub-word loads from 0x80FF1234.
    mem[4] = 32'h80FF1234;
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
    observe(6);
    check("lb_lat", 32'(lat(6)), 32'd3);
    check("lb_s", lg_rd[3], 32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
    observe(6);
    check("lbu", lg_rd[3], 32'h00000080);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    observe(6);
    check("lb_pos", lg_rd[3], 32'h00000012);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    observe(6);
    check("lh_s", lg_rd[3], 32'hFFFF80FF);
    issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b0);
    observe(6);
    check("lhu", lg_rd[3], 32'h00001234);

    // Half store 0xABCD at 0x0A over 0x11223344.
    mem[2] = 32'h11223344;
    issue(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000ABCD, 1'b0);
    observe(7);
    check("sh_rd_req", {30'b0, lg_req[1], lg_we[1]}, 32'd2);
    check("sh_rd_addr", lg_addr[1], 32'd2);
    check("sh_wr_req", {30'b0, lg_req[3], lg_we[3]}, 32'd3);
    check("sh_wr_data", lg_wd[3], 32'hABCD3344);
    check("sh_lat", 32'(lat(7)), 32'd4);
    check("sh_rdata", lg_rd[4], 32'd0);
    check("sh_mem", mem[2], 32'hABCD3344);

    // Byte store 0x5A at 0x05 over 0xAABBCCDD.
    mem[1] = 32'hAABBCCDD;
    issue(1'b1, 2'd0, 1'b0, 32'h05, 32'hFFFFFF5A, 1'b0);
    observe(7);
    check("sb_lat", 32'(lat(7)), 32'd4);
    check("sb_mem", mem[1], 32'hAABB5ADD);

    // Word store at 0x0C.
    issue(1'b1, 2'd2, 1'b0, 32'h0C, 32'h12345678, 1'b0);
    observe(5);
    check("sw_wr", {30'b0, lg_req[1], lg_we[1]}, 32'd3);
    check("sw_lat", 32'(lat(5)), 32'd2);
    check("sw_mem", mem[3], 32'h12345678);

    // Illegal size code.
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0);
    observe(4);
    check("sz3_lat", 32'(lat(4)), 32'd1);
    check("sz3_err", {31'b0, lg_err[1]}, 32'd1);

    // Misaligned word load at 0x06.
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0);
    observe(4);
    check("mis_lat", 32'(lat(4)), 32'd1);
    check("mis_err", {31'b0, lg_err[1]}, 32'd1);
    check("mis_rdata", lg_rd[1], 32'd0);
    check("mis_noreq", 32'(nreq(4)), 32'd0);

    // Back-to-back loads with cmd_valid held high.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    cmd_addr = 32'h0C;
    observe(7);
    cmd_valid = 1'b0;
    check("b2b_err_clr", {31'b0, lg_err[1]}, 32'd0);
    check("b2b_rdy3", {31'b0, lg_rdy[3]}, 32'd0);
    check("b2b_rv3", {31'b0, lg_rv[3]}, 32'd1);
    check("b2b_rdy4", {31'b0, lg_rdy[4]}, 32'd1);
    check("b2b_rdy5", {31'b0, lg_rdy[5]}, 32'd0);
    check("b2b_rv7", {31'b0, lg_rv[7]}, 32'd1);
    check("b2b_data", lg_rd[7], 32'h12345678);
    observe(4);

    // Reset during RMW_MERGE of a byte store.
    mem[0] = 32'h11111111;
    issue(1'b1, 2'd0, 1'b0, 32'h00, 32'h000000EE, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_req", {31'b0, mem_request}, 32'd0);
    check("abort_rv", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    observe(5);
    check("abort_rdy", {31'b0, lg_rdy[1]}, 32'd1);
    check("abort_norsp", 32'(lat(5)), 32'd0);
    check("abort_noreq", 32'(nreq(5)), 32'd0);
    check("abort_mem", mem[0], 32'h11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
